bounded_rng: RTL and testbench

BOUNDED_RNG -- requirements
Module: bounded_rng

---
 rtl/bounded_rng_pkg.sv | 49 ++++
 rtl/rng_lfsr.sv | 45 ++++
 rtl/bounded_rng.sv | 143 ++++++++++++++
 tb/tb_bounded_rng.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bounded_rng_pkg.sv
// Shared definitions for bounded_rng: FSM state encoding, Galois LFSR tap
// masks per supported width (16/32/64/128), and the bit-smearing helpers
// used to build the rejection mask and to step the LFSR.
package bounded_rng_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // Galois (right-shifting) tap masks; bit k-1 set for polynomial term x^k.
    // 16:  x^16 + x^15 + x^13 + x^4 + 1
    // 32:  x^32 + x^22 + x^2 + x + 1
    // 64:  x^64 + x^63 + x^61 + x^60 + 1
    // 128: x^128 + x^126 + x^101 + x^99 + 1
    localparam logic [127:0] TAPS_16  = 128'h0000_D008;
    localparam logic [127:0] TAPS_32  = 128'h8020_0003;
    localparam logic [127:0] TAPS_64  = 128'hD800_0000_0000_0000;
    localparam logic [127:0] TAPS_128 = 128'hA000_0014_0000_0000_0000_0000_0000_0000;

    function automatic logic [127:0] lfsr_taps(input int width);
        logic [127:0] t;
        case (width)
            16:      t = TAPS_16;
            64:      t = TAPS_64;
            128:     t = TAPS_128;
            default: t = TAPS_32;
        endcase
        return t;
    endfunction

    // One Galois step; operands are zero-extended to 128 bits by the caller.
    function automatic logic [127:0] galois_step(input logic [127:0] s,
                                                 input logic [127:0] taps);
        return (s >> 1) ^ (s[0] ? taps : 128'd0);
    endfunction

    // All ones from the most significant set bit downwards.
    function automatic logic [127:0] smear_mask(input logic [127:0] v);
        logic [127:0] m;
        m = v;
        for (int sh = 1; sh < 128; sh = sh * 2) begin
            m = m | (m >> sh);
        end
        return m;
    endfunction

endpackage

// File: rtl/rng_lfsr.sv
// Maximal-length Galois LFSR of WIDTH bits. Steps only when asked, can be
// loaded with an external value, and never holds zero (zero loads and a
// zero SEED are replaced by 1).
module rng_lfsr
    import bounded_rng_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(7823)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] RESET_VAL = (SEED == '0) ? WIDTH'(1) : SEED;
    localparam logic [127:0]     TAPS      = lfsr_taps(WIDTH);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // Next state: load wins over step, otherwise hold.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_val == '0) ? WIDTH'(1) : load_val;
        end else if (step) begin
            state_d = WIDTH'(galois_step(128'(state_q), TAPS));
        end
    end

    // State register, reseeded by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/bounded_rng.sv
// bounded_rng: returns a uniformly distributed value in [1, bound-1] by
// masked rejection sampling on a Galois LFSR. A request is accepted only in
// IDLE; DRAW tries one candidate per cycle; HOLD presents the result until
// the consumer takes it. Too many rejections or bound<2 give an err pulse.
// Optional macro BOUNDED_RNG_RESEED_EN adds seed_load/seed_val for runtime
// reseeding in IDLE.
module bounded_rng
    import bounded_rng_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(7823),
    parameter int               MAX_TRIES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] bound,
    output logic [WIDTH-1:0] rnd,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             err
`ifdef BOUNDED_RNG_RESEED_EN
    ,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val
`endif
);

    localparam int               TRY_W    = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES);
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [127:0]     TAPS     = lfsr_taps(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] rnd_q;
    logic             valid_q;
    logic             busy_q;
    logic             err_q;
    logic [TRY_W-1:0] tries_q;
    logic [WIDTH-1:0] bound_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] lfsr_state;
    logic [WIDTH-1:0] cand;
    logic             cand_ok;
    logic             seed_take;
    logic [WIDTH-1:0] seed_word;
    logic             req_take;

`ifdef BOUNDED_RNG_RESEED_EN
    assign seed_take = seed_load && (state_q == S_IDLE);
    assign seed_word = seed_val;
`else
    assign seed_take = 1'b0;
    assign seed_word = '0;
`endif

    // A reseed in IDLE swallows any simultaneous request.
    assign req_take = req && !seed_take && (state_q == S_IDLE);
    assign mask_d   = WIDTH'(smear_mask(128'(bound - WIDTH'(1))));

    // Candidate is the value the LFSR moves to on this DRAW cycle.
    assign cand    = WIDTH'(galois_step(128'(lfsr_state), TAPS)) & mask_q;
    assign cand_ok = (cand != '0) && (cand < bound_q);

    rng_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (state_q == S_DRAW),
        .load     (seed_take),
        .load_val (seed_word),
        .state    (lfsr_state)
    );

    // Request operands, captured on acceptance and frozen afterwards.
    always_ff @(posedge clk) begin
        if (req_take) begin
            bound_q <= bound;
            mask_q  <= mask_d;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            tries_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_take) begin
                        if (bound < WIDTH'(2)) begin
                            err_q <= 1'b1;
                        end else begin
                            tries_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_DRAW;
                        end
                    end
                end
                S_DRAW: begin
                    if (cand_ok) begin
                        rnd_q   <= cand;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_HOLD;
                    end else if (tries_q == LAST_TRY) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tries_q <= tries_q + TRY_W'(1);
                    end
                end
                S_HOLD: begin
                    if (ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rnd   = rnd_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bounded_rng.sv
// Testbench for bounded_rng: two instances (default MAX_TRIES=64 and
// MAX_TRIES=1) on a shared clock/reset, compared against a request-level
// reference model of rejection sampling on the 32-bit Galois LFSR.
`timescale 1ns/1ps
module tb_bounded_rng;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] POLY  = 32'h8020_0003;
    localparam logic [31:0] SEED0 = 32'd7823;
    localparam logic [31:0] GB    = 32'd4157295846;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       req_a;
    logic [1:0]       ready_a;
    logic [1:0][31:0] bound_a;
    logic             seed_load;
    logic [31:0]      seed_val;

    logic [31:0] rnd0, rnd1;
    logic        valid0, valid1, busy0, busy1, err0, err1;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_lfsr [2];
    logic [31:0] golden [10];

    bounded_rng #(.WIDTH(32), .SEED(32'd7823), .MAX_TRIES(64)) u_dut0 (
        .clk   (clk),
        .rst   (rst),
        .req   (req_a[0]),
        .bound (bound_a[0]),
        .rnd   (rnd0),
        .valid (valid0),
        .ready (ready_a[0]),
        .busy  (busy0),
        .err   (err0)
`ifdef BOUNDED_RNG_RESEED_EN
        ,
        .seed_load (seed_load),
        .seed_val  (seed_val)
`endif
    );

    bounded_rng #(.WIDTH(32), .SEED(32'd7823), .MAX_TRIES(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .req   (req_a[1]),
        .bound (bound_a[1]),
        .rnd   (rnd1),
        .valid (valid1),
        .ready (ready_a[1]),
        .busy  (busy1),
        .err   (err1)
`ifdef BOUNDED_RNG_RESEED_EN
        ,
        .seed_load (1'b0),
        .seed_val  (32'd0)
`endif
    );

    function automatic logic [31:0] f_rnd(input int u);
        return (u == 0) ? rnd0 : rnd1;
    endfunction
    function automatic logic f_valid(input int u);
        return (u == 0) ? valid0 : valid1;
    endfunction
    function automatic logic f_busy(input int u);
        return (u == 0) ? busy0 : busy1;
    endfunction
    function automatic logic f_err(input int u);
        return (u == 0) ? err0 : err1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    // Request-level model: smallest 2^k-1 covering bound-1, draw until a
    // value lands in [1, bound-1] or the try budget runs out.
    task automatic model_req(input int u, input logic [31:0] b,
                             output bit is_err, output logic [31:0] val, output int draws);
        longint unsigned mask;
        int              budget;
        logic [31:0]     c;
        is_err = 1'b0;
        val    = '0;
        draws  = 0;
        if (b < 32'd2) begin
            is_err = 1'b1;
            return;
        end
        budget = (u == 0) ? 64 : 1;
        mask = 0;
        while (mask < longint'(b) - 1) mask = mask * 2 + 1;
        for (int t = 1; t <= budget; t++) begin
            m_lfsr[u] = lfsr_adv(m_lfsr[u]);
            c = m_lfsr[u] & mask[31:0];
            if (c >= 32'd1 && c < b) begin
                val   = c;
                draws = t;
                return;
            end
        end
        is_err = 1'b1;
        draws  = budget;
    endtask

    // Issue one request and check timing, result and err against the model.
    task automatic do_req(input int u, input logic [31:0] b,
                          output logic [31:0] got, output bit got_err, output bit exp_err);
        bit          e;
        logic [31:0] v;
        int          d;
        int          cyc;
        model_req(u, b, e, v, d);
        exp_err = e;
        got     = '0;
        @(negedge clk);
        req_a[u]   = 1'b1;
        bound_a[u] = b;
        @(negedge clk);
        req_a[u]   = 1'b0;
        bound_a[u] = $urandom;
        chk("busy_after_accept", f_busy(u), (d > 0));
        cyc = 1;
        while (!f_valid(u) && !f_err(u) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, d + 1);
        got_err = f_err(u);
        if (e) begin
            chk("err", f_err(u), 1);
            chk("valid_on_err", f_valid(u), 0);
            @(negedge clk);
            chk("err_pulse", f_err(u), 0);
            chk("valid_after_err", f_valid(u), 0);
        end else begin
            chk("valid", f_valid(u), 1);
            chk("rnd", f_rnd(u), v);
            got = f_rnd(u);
            if (ready_a[u]) begin
                @(negedge clk);
                chk("valid_drop", f_valid(u), 0);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rnd", rnd0, 0);
        chk("rst_valid", valid0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_err", err0, 0);
        chk("rst_valid1", valid1, 0);
        rst = 1'b0;
        m_lfsr[0] = SEED0;
        m_lfsr[1] = SEED0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        bit          e, me;
        int          obs_errs, mdl_errs;

        rst       = 1'b1;
        req_a     = '0;
        ready_a   = 2'b11;
        bound_a   = '0;
        seed_load = 1'b0;
        seed_val  = '0;

        apply_reset();

        // Golden sequence after reset
        for (int i = 0; i < 10; i++) begin
            do_req(0, GB, v, e, me);
            golden[i] = v;
            chk("golden_range", (v >= 32'd1 && v <= 32'd4157295845), 1);
        end

        // Degenerate bounds, then a normal request
        do_req(0, 32'd1, v, e, me);
        do_req(0, 32'd0, v, e, me);
        do_req(0, 32'd100, v, e, me);
        chk("after_err_ok", (v >= 32'd1 && v < 32'd100), 1);

        // bound=2 always yields 1
        for (int i = 0; i < 5; i++) begin
            do_req(0, 32'd2, v, e, me);
            chk("bound2_one", v, 1);
        end

        // bound=3 with a single try: err whenever first candidate is 0 or 3
        obs_errs = 0;
        mdl_errs = 0;
        for (int i = 0; i < 30; i++) begin
            do_req(1, 32'd3, v, e, me);
            if (e) obs_errs++;
            if (me) mdl_errs++;
        end
        chk("bound3_err_count", obs_errs, mdl_errs);

        // Back-pressure in HOLD; requests there are ignored
        ready_a[0] = 1'b0;
        do_req(0, 32'd1000, v, e, me);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req_a[0]   = i[0];
            bound_a[0] = 32'd5;
            chk("hold_valid", valid0, 1);
            chk("hold_rnd", rnd0, v);
        end
        @(negedge clk);
        req_a[0]   = 1'b0;
        ready_a[0] = 1'b1;
        chk("hold_last_valid", valid0, 1);
        @(negedge clk);
        chk("hold_release_valid", valid0, 0);
        chk("hold_release_busy", busy0, 0);
        @(negedge clk);
        chk("no_queued_req", busy0, 0);

        // Randomized requests on both instances
        for (int i = 0; i < 24; i++) begin
            int          u;
            int          k;
            logic [31:0] b;
            u = $urandom_range(0, 1);
            k = $urandom_range(0, 3);
            case (k)
                0:       b = $urandom_range(0, 20);
                1:       b = $urandom;
                2:       b = (32'd1 << $urandom_range(1, 31)) + 32'd1;
                default: b = $urandom_range(2, 1000);
            endcase
            do_req(u, b, v, e, me);
            if (!e) chk("rand_range", (v >= 32'd1 && v < b), 1);
        end

        // Reset in the middle of DRAW
        @(negedge clk);
        req_a[0]   = 1'b1;
        bound_a[0] = GB;
        @(negedge clk);
        req_a[0] = 1'b0;
        chk("middraw_busy", busy0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("middraw_rst_rnd", rnd0, 0);
        chk("middraw_rst_valid", valid0, 0);
        chk("middraw_rst_busy", busy0, 0);
        chk("middraw_rst_err", err0, 0);
        rst = 1'b0;
        m_lfsr[0] = SEED0;
        m_lfsr[1] = SEED0;
        for (int i = 0; i < 5; i++) begin
            do_req(0, GB, v, e, me);
            chk("replay_golden", v, golden[i]);
        end

`ifdef BOUNDED_RNG_RESEED_EN
        // Reseed with a simultaneous request: reload only
        @(negedge clk);
        seed_load  = 1'b1;
        seed_val   = 32'h1234;
        req_a[0]   = 1'b1;
        bound_a[0] = GB;
        @(negedge clk);
        seed_load = 1'b0;
        req_a[0]  = 1'b0;
        chk("reseed_no_req", busy0, 0);
        m_lfsr[0] = 32'h1234;
        for (int i = 0; i < 5; i++) begin
            do_req(0, $urandom_range(2, 100000), v, e, me);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
